// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Instruction-fetch controller between a combinational instruction memory and
// the decode stage. It owns the program counter and presents it on mem_pc every
// cycle. It captures the returned word together with its PC in a 2-entry buffer.
// The buffer head goes to decode over a valid/ready handshake.
//
// Ports:
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   run              in   1 = fetching enabled, 0 = freeze PC and let the buffer drain
//   mem_pc           out  instruction memory address (the fetch PC register)
//   mem_instruction  in   word returned by memory for mem_pc, same cycle
//   redirect_valid   in   branch/jump redirect; flushes the buffer
//   redirect_pc      in   redirect target (values above LAST_ADDR map to 0)
//   out_valid        out  buffer head holds an instruction
//   out_ready        in   decode accepts the head this cycle
//   out_instruction  out  head instruction word
//   out_pc           out  address of the head instruction
module fetch_sequencer #(
    parameter int unsigned PC_WIDTH          = 8,
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter int unsigned LAST_ADDR         = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    output logic [PC_WIDTH-1:0]          mem_pc,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_instruction,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
    output logic [PC_WIDTH-1:0]          out_pc
);

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(LAST_ADDR);
    localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] PC_ZERO = '0;

    // Entry 0 is always the head; entry 1 shifts down on a pop.
    logic [PC_WIDTH-1:0]          fetch_pc_q, fetch_pc_d;
    logic [1:0]                   count_q, count_d;
    logic [PC_WIDTH-1:0]          pc0_q, pc0_d, pc1_q, pc1_d;
    logic [INSTRUCTION_WIDTH-1:0] ins0_q, ins0_d, ins1_q, ins1_d;

    logic                         pop;
    logic                         push;
    logic [1:0]                   occ_after_pop;
    logic [PC_WIDTH-1:0]          next_seq_pc;
    logic [PC_WIDTH-1:0]          redirect_target;

    assign mem_pc          = fetch_pc_q;
    assign out_valid       = (count_q != 2'd0);
    assign out_pc          = pc0_q;
    assign out_instruction = ins0_q;

    assign pop           = out_valid & out_ready;
    assign occ_after_pop = count_q - {1'b0, pop};
    assign push          = run & ~redirect_valid & (occ_after_pop < 2'd2);

    // Wrap is by explicit compare so a LAST_ADDR below the PC_WIDTH maximum
    // still cycles over the loaded program only.
    assign next_seq_pc     = (fetch_pc_q == LAST_PC) ? PC_ZERO : fetch_pc_q + PC_ONE;
    assign redirect_target = (redirect_pc > LAST_PC) ? PC_ZERO : redirect_pc;

    always_comb begin
        pc0_d      = pc0_q;
        ins0_d     = ins0_q;
        pc1_d      = pc1_q;
        ins1_d     = ins1_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = occ_after_pop;

        if (pop) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
        end

        // The new entry lands in the first slot left free after this cycle's pop.
        if (push) begin
            if (occ_after_pop == 2'd0) begin
                pc0_d  = fetch_pc_q;
                ins0_d = mem_instruction;
            end else begin
                pc1_d  = fetch_pc_q;
                ins1_d = mem_instruction;
            end
            count_d    = occ_after_pop + 2'd1;
            fetch_pc_d = next_seq_pc;
        end

        // Redirect discards everything still buffered, including the entry
        // being pushed in the same cycle (push is already suppressed).
        if (redirect_valid) begin
            count_d    = 2'd0;
            fetch_pc_d = redirect_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= '0;
            count_q    <= 2'd0;
            pc0_q      <= '0;
            pc1_q      <= '0;
            ins0_q     <= '0;
            ins1_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            ins0_q     <= ins0_d;
            ins1_q     <= ins1_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic clk;
    logic rst_n;

    // Instance A: default LAST_ADDR = 255
    logic        run_a, out_ready_a, redirect_valid_a, out_valid_a;
    logic [7:0]  redirect_pc_a, mem_pc_a, out_pc_a;
    logic [15:0] mem_instruction_a, out_instruction_a;

    // Instance B: LAST_ADDR = 11
    logic        run_b, out_ready_b, redirect_valid_b, out_valid_b;
    logic [7:0]  redirect_pc_b, mem_pc_b, out_pc_b;
    logic [15:0] mem_instruction_b, out_instruction_b;

    int n_checks;
    int n_pass;

    // Memory contents: word = address + 0x1000
    assign mem_instruction_a = 16'h1000 + {8'h00, mem_pc_a};
    assign mem_instruction_b = 16'h1000 + {8'h00, mem_pc_b};

    fetch_sequencer dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run_a),
        .mem_pc          (mem_pc_a),
        .mem_instruction (mem_instruction_a),
        .redirect_valid  (redirect_valid_a),
        .redirect_pc     (redirect_pc_a),
        .out_valid       (out_valid_a),
        .out_ready       (out_ready_a),
        .out_instruction (out_instruction_a),
        .out_pc          (out_pc_a)
    );

    fetch_sequencer #(
        .PC_WIDTH          (8),
        .INSTRUCTION_WIDTH (16),
        .LAST_ADDR         (11)
    ) dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run_b),
        .mem_pc          (mem_pc_b),
        .mem_instruction (mem_instruction_b),
        .redirect_valid  (redirect_valid_b),
        .redirect_pc     (redirect_pc_b),
        .out_valid       (out_valid_b),
        .out_ready       (out_ready_b),
        .out_instruction (out_instruction_b),
        .out_pc          (out_pc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs driven for one cycle plus the registered outputs expected in that cycle.
    typedef struct {
        logic       run;
        logic       rdy;
        logic       rv;
        logic [7:0] rpc;
        logic       ev;
        logic [7:0] epc;
        logic [7:0] emp;
    } vec_t;

    vec_t va[27];
    vec_t vb[22];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    // Called at a negedge: compare current outputs, then drive the inputs for the next edge.
    task automatic apply_vec(input bit sel, input int idx, input vec_t v);
        logic        g_v;
        logic [7:0]  g_pc, g_mp;
        logic [15:0] g_ins;
        string       tn;
        tn = sel ? "B" : "A";
        if (!sel) begin
            g_v = out_valid_a; g_pc = out_pc_a; g_mp = mem_pc_a; g_ins = out_instruction_a;
        end else begin
            g_v = out_valid_b; g_pc = out_pc_b; g_mp = mem_pc_b; g_ins = out_instruction_b;
        end
        check($sformatf("%s[%0d].out_valid", tn, idx), {31'd0, g_v}, {31'd0, v.ev});
        check($sformatf("%s[%0d].mem_pc", tn, idx), {24'd0, g_mp}, {24'd0, v.emp});
        if (v.ev) begin
            check($sformatf("%s[%0d].out_pc", tn, idx), {24'd0, g_pc}, {24'd0, v.epc});
            check($sformatf("%s[%0d].out_instruction", tn, idx), {16'd0, g_ins},
                  {16'd0, 16'h1000 + {8'h00, v.epc}});
        end
        if (!sel) begin
            run_a = v.run; out_ready_a = v.rdy; redirect_valid_a = v.rv; redirect_pc_a = v.rpc;
        end else begin
            run_b = v.run; out_ready_b = v.rdy; redirect_valid_b = v.rv; redirect_pc_b = v.rpc;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        //          run   rdy   rv    rpc    | ev    epc    emp
        // Stream, stall from cycle 3 for 5 cycles, redirect 0x40 with 2 buffered,
        // run drop with 2 buffered, redirect while stopped, redirect to LAST_ADDR.
        va[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
        va[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01};
        va[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h02};
        va[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h03};
        va[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h04};
        va[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h04};
        va[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h04};
        va[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 8'h04};
        va[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'h04};
        va[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 8'h05};
        va[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 8'h06};
        va[11] = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 8'h05, 8'h07};
        va[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h40};
        va[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 8'h41};
        va[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 8'h42};
        va[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 8'h42};
        va[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 8'h42};
        va[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h42};
        va[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h42};
        va[19] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h42, 8'h43};
        va[20] = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 8'h43, 8'h44};
        va[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h10};
        va[22] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h10};
        va[23] = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h10, 8'h11};
        va[24] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'hFF};
        va[25] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h00};
        va[26] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01};

        // LAST_ADDR = 11: free-running wrap, redirect 200 -> 0, redirect 11, redirect 12 -> 0.
        vb[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
        vb[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01};
        vb[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 8'h02};
        vb[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 8'h03};
        vb[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 8'h04};
        vb[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 8'h05};
        vb[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 8'h06};
        vb[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 8'h07};
        vb[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h07, 8'h08};
        vb[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 8'h09};
        vb[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h09, 8'h0A};
        vb[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0A, 8'h0B};
        vb[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0B, 8'h00};
        vb[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01};
        vb[14] = '{1'b1, 1'b1, 1'b1, 8'hC8, 1'b1, 8'h01, 8'h02};
        vb[15] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
        vb[16] = '{1'b1, 1'b1, 1'b1, 8'h0B, 1'b1, 8'h00, 8'h01};
        vb[17] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h0B};
        vb[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0B, 8'h00};
        vb[19] = '{1'b1, 1'b1, 1'b1, 8'h0C, 1'b1, 8'h00, 8'h01};
        vb[20] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
        vb[21] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h01};

        rst_n = 1'b0;
        run_a = 1'b0; out_ready_a = 1'b0; redirect_valid_a = 1'b0; redirect_pc_a = 8'h00;
        run_b = 1'b0; out_ready_b = 1'b0; redirect_valid_b = 1'b0; redirect_pc_b = 8'h00;

        repeat (2) @(negedge clk);
        // Reset state of the head entry
        check("reset.out_pc", {24'd0, out_pc_a}, 32'd0);
        check("reset.out_instruction", {16'd0, out_instruction_a}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            apply_vec(1'b0, i, va[i]);
            @(negedge clk);
        end
        for (int i = 0; i < 22; i++) begin
            apply_vec(1'b1, i, vb[i]);
            @(negedge clk);
        end

        // Instance A kept streaming; assert reset between edges.
        @(posedge clk);
        #2;
        check("midrst.pre_valid", {31'd0, out_valid_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", {31'd0, out_valid_a}, 32'd0);
        check("midrst.mem_pc", {24'd0, mem_pc_a}, 32'd0);
        check("midrst.out_pc", {24'd0, out_pc_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.rel_valid", {31'd0, out_valid_a}, 32'd0);
        @(negedge clk);
        check("midrst.first_valid", {31'd0, out_valid_a}, 32'd1);
        check("midrst.first_pc", {24'd0, out_pc_a}, 32'd0);
        check("midrst.first_ins", {16'd0, out_instruction_a}, 32'h1000);
        check("midrst.first_mem_pc", {24'd0, mem_pc_a}, 32'd1);
        @(negedge clk);
        check("midrst.second_pc", {24'd0, out_pc_a}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
